// File: rtl/hue_pwm_pkg.sv
// ----------------------------------------------------------------------------
// hue_pwm_pkg
// Shared types and helpers for the hue-rotating RGB PWM driver.
//   mode_e       : operating mode encoding of the 2-bit mode input
//   SEG_COUNT    : number of hue segments in one full colour circle
//   duty_shape_e : how one channel's duty is derived within a segment
//   hue_to_duty  : per-segment {r,g,b} duty shapes (width independent; the
//                  top applies the shapes to its own hue fraction)
// ----------------------------------------------------------------------------
package hue_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_HOLD = 2'd1,
    MODE_STEP = 2'd2,
    MODE_REV  = 2'd3
  } mode_e;

  localparam int SEG_COUNT = 6;

  // OFF = 0, FULL = MAX, UP = frac, DOWN = MAX - frac
  typedef enum logic [1:0] {
    DUTY_OFF  = 2'd0,
    DUTY_FULL = 2'd1,
    DUTY_UP   = 2'd2,
    DUTY_DOWN = 2'd3
  } duty_shape_e;

  typedef struct packed {
    duty_shape_e r;
    duty_shape_e g;
    duty_shape_e b;
  } duty_shape_t;

  // Colour wheel: each segment ramps exactly one channel up or down.
  // Kept as shapes so the package stays independent of PWM_BITS.
  function automatic duty_shape_t hue_to_duty(input logic [2:0] seg);
    duty_shape_t d;
    case (seg)
      3'd0:    d = '{r: DUTY_FULL, g: DUTY_UP,   b: DUTY_OFF};
      3'd1:    d = '{r: DUTY_DOWN, g: DUTY_FULL, b: DUTY_OFF};
      3'd2:    d = '{r: DUTY_OFF,  g: DUTY_FULL, b: DUTY_UP};
      3'd3:    d = '{r: DUTY_OFF,  g: DUTY_DOWN, b: DUTY_FULL};
      3'd4:    d = '{r: DUTY_UP,   g: DUTY_OFF,  b: DUTY_FULL};
      3'd5:    d = '{r: DUTY_FULL, g: DUTY_OFF,  b: DUTY_DOWN};
      default: d = '{r: DUTY_OFF,  g: DUTY_OFF,  b: DUTY_OFF};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// ----------------------------------------------------------------------------
// pwm_channel
// One PWM output: latches its duty at the frame boundary (pwm_cnt == MAX),
// compares against the shared counter and drives a registered pin.
//   clk, rst_n : clock, asynchronous active-low reset
//   pwm_cnt    : shared free-running frame counter
//   duty_in    : requested duty, sampled only at the frame boundary
//   pin        : registered LED pin, idle level per ACTIVE_LOW
// ----------------------------------------------------------------------------
module pwm_channel #(
  parameter int PWM_BITS   = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [PWM_BITS-1:0] duty_in,
  output logic                pin
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  localparam logic                PIN_OFF = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [PWM_BITS-1:0] duty_r;
  logic                on_s;
  logic                pin_r;

  // Channel on while the latched duty exceeds the frame position.
  always_comb begin
    on_s = (duty_r > pwm_cnt);
  end

  // Duty latch: a new value only ever starts on a fresh frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_r <= '0;
    end else if (pwm_cnt == CNT_MAX) begin
      duty_r <= duty_in;
    end
  end

  // Output register with polarity applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_r <= PIN_OFF;
    end else begin
      pin_r <= on_s ? ~PIN_OFF : PIN_OFF;
    end
  end

  assign pin = pin_r;

endmodule

// File: rtl/hue_pwm_driver.sv
// ----------------------------------------------------------------------------
// hue_pwm_driver
// Rotates hue through 6 segments x 2**PWM_BITS levels and drives the RGB LED
// pins with PWM. Modes: run, hold, single-step (step_req rising edge) and
// reverse run.
//   clk, rst_n        : clock, asynchronous active-low reset
//   mode              : 00 run, 01 hold, 10 single-step, 11 reverse run
//   step_req          : synchronous step request (single-step mode only)
//   RGB_R/RGB_G/RGB_B : registered LED pins
//   hue_seg, hue_frac : current hue position
//   wrap              : one-cycle pulse when the hue crosses segment 5<->0
// ----------------------------------------------------------------------------
module hue_pwm_driver
  import hue_pwm_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 4_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic                step_req,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B,
  output logic [2:0]          hue_seg,
  output logic [PWM_BITS-1:0] hue_frac,
  output logic                wrap
);

  localparam int                  DIV_W    = $clog2(STEP_DIV);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] FRAC_MAX = '1;
  localparam logic [2:0]          SEG_LAST = 3'(SEG_COUNT - 1);

  if (STEP_DIV < 2 || CLK_HZ < 1) begin : g_bad_params
    $error("hue_pwm_driver: STEP_DIV must be >= 2 and CLK_HZ positive");
  end

  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [DIV_W-1:0]    div_cnt_r;
  logic [2:0]          seg_r;
  logic [PWM_BITS-1:0] frac_r;
  logic                wrap_r;
  logic [1:0]          mode_r;
  logic                step_prev_r;

  mode_e               mode_s;
  logic                mode_changed_s;
  logic [DIV_W-1:0]    div_base_s;
  logic [DIV_W-1:0]    div_next_s;
  logic                tick_s;
  logic                step_edge_s;
  logic                fwd_s;
  logic                rev_s;
  logic [2:0]          seg_next_s;
  logic [PWM_BITS-1:0] frac_next_s;
  logic                wrap_next_s;
  duty_shape_t         shape_s;
  logic [PWM_BITS-1:0] duty_r_s;
  logic [PWM_BITS-1:0] duty_g_s;
  logic [PWM_BITS-1:0] duty_b_s;

  function automatic logic [PWM_BITS-1:0] shape_duty(input duty_shape_e s,
                                                     input logic [PWM_BITS-1:0] f);
    logic [PWM_BITS-1:0] d;
    case (s)
      DUTY_OFF:  d = '0;
      DUTY_FULL: d = FRAC_MAX;
      DUTY_UP:   d = f;
      DUTY_DOWN: d = FRAC_MAX - f;
      default:   d = '0;
    endcase
    return d;
  endfunction

  // Step timing. A mode change restarts the divider from zero in the same
  // cycle, so the first tick after any change is a full STEP_DIV cycles away.
  always_comb begin
    mode_s         = mode_e'(mode);
    mode_changed_s = (mode != mode_r);
    div_base_s     = mode_changed_s ? '0 : div_cnt_r;
    div_next_s     = '0;
    tick_s         = 1'b0;
    step_edge_s    = 1'b0;
    case (mode_s)
      MODE_RUN, MODE_REV: begin
        if (div_base_s == DIV_LAST) begin
          tick_s = 1'b1;
        end else begin
          div_next_s = div_base_s + DIV_W'(1);
        end
      end
      MODE_STEP: begin
        step_edge_s = !mode_changed_s && step_req && !step_prev_r;
      end
      default: begin
        step_edge_s = 1'b0;
      end
    endcase
    fwd_s = step_edge_s || (tick_s && (mode_s == MODE_RUN));
    rev_s = tick_s && (mode_s == MODE_REV);
  end

  // Hue stepper: fraction carries/borrows into the segment, segment wraps 5<->0.
  always_comb begin
    seg_next_s  = seg_r;
    frac_next_s = frac_r;
    wrap_next_s = 1'b0;
    if (fwd_s) begin
      if (frac_r == FRAC_MAX) begin
        frac_next_s = '0;
        if (seg_r == SEG_LAST) begin
          seg_next_s  = 3'd0;
          wrap_next_s = 1'b1;
        end else begin
          seg_next_s = seg_r + 3'd1;
        end
      end else begin
        frac_next_s = frac_r + PWM_BITS'(1);
      end
    end else if (rev_s) begin
      if (frac_r == '0) begin
        frac_next_s = FRAC_MAX;
        if (seg_r == 3'd0) begin
          seg_next_s  = SEG_LAST;
          wrap_next_s = 1'b1;
        end else begin
          seg_next_s = seg_r - 3'd1;
        end
      end else begin
        frac_next_s = frac_r - PWM_BITS'(1);
      end
    end else begin
      wrap_next_s = 1'b0;
    end
  end

  // Duties from the current (pre-step) hue; channels sample them at frame end.
  always_comb begin
    shape_s  = hue_to_duty(seg_r);
    duty_r_s = shape_duty(shape_s.r, frac_r);
    duty_g_s = shape_duty(shape_s.g, frac_r);
    duty_b_s = shape_duty(shape_s.b, frac_r);
  end

  // Free-running frame counter; wraps naturally at MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r <= '0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
    end
  end

  // Divider, mode tracking and step_req edge register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r   <= '0;
      mode_r      <= MODE_RUN;
      step_prev_r <= 1'b0;
    end else begin
      div_cnt_r   <= div_next_s;
      mode_r      <= mode;
      step_prev_r <= mode_changed_s ? 1'b0 : step_req;
    end
  end

  // Hue position and wrap pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r  <= 3'd0;
      frac_r <= '0;
      wrap_r <= 1'b0;
    end else begin
      seg_r  <= seg_next_s;
      frac_r <= frac_next_s;
      wrap_r <= wrap_next_s;
    end
  end

  pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_chan_r (
    .clk(clk), .rst_n(rst_n), .pwm_cnt(pwm_cnt_r), .duty_in(duty_r_s), .pin(RGB_R)
  );
  pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_chan_g (
    .clk(clk), .rst_n(rst_n), .pwm_cnt(pwm_cnt_r), .duty_in(duty_g_s), .pin(RGB_G)
  );
  pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_chan_b (
    .clk(clk), .rst_n(rst_n), .pwm_cnt(pwm_cnt_r), .duty_in(duty_b_s), .pin(RGB_B)
  );

  assign hue_seg  = seg_r;
  assign hue_frac = frac_r;
  assign wrap     = wrap_r;

endmodule

// File: tb/tb_hue_pwm_driver.sv
// ----------------------------------------------------------------------------
// tb_hue_pwm_driver
// Self-checking bench: directed scenarios plus randomized mode/step_req
// traffic, all compared every cycle against a behavioural model that tracks
// hue as a single position 0..47 on the colour circle.
// ----------------------------------------------------------------------------
module tb_hue_pwm_driver;

  localparam int PB     = 3;
  localparam int SD     = 4;
  localparam int MAXV   = 7;
  localparam int LEVELS = 8;
  localparam int NPOS   = 48;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       step_req = 1'b0;
  logic       rgb_r, rgb_g, rgb_b;
  logic [2:0] hue_seg;
  logic [2:0] hue_frac;
  logic       wrap;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int         m_pos, m_cnt, m_age, m_wrap, m_req_prev;
  int         m_duty[3];
  int         m_pin[3];
  logic [1:0] m_mode_prev;

  always #5 clk = ~clk;

  hue_pwm_driver #(.CLK_HZ(12_000_000), .PWM_BITS(PB), .STEP_DIV(SD), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .step_req(step_req),
    .RGB_R(rgb_r), .RGB_G(rgb_g), .RGB_B(rgb_b),
    .hue_seg(hue_seg), .hue_frac(hue_frac), .wrap(wrap)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Colour-wheel table straight from the hue->duty rules.
  function automatic int ref_duty(input int ch, input int pos);
    int seg = pos / LEVELS;
    int f   = pos % LEVELS;
    int rgb[3];
    case (seg)
      0:       rgb = '{MAXV, f, 0};
      1:       rgb = '{MAXV - f, MAXV, 0};
      2:       rgb = '{0, MAXV, f};
      3:       rgb = '{0, MAXV - f, MAXV};
      4:       rgb = '{f, 0, MAXV};
      default: rgb = '{MAXV, 0, MAXV - f};
    endcase
    return rgb[ch];
  endfunction

  task automatic model_reset();
    m_pos = 0; m_cnt = 0; m_age = 0; m_wrap = 0; m_req_prev = 0;
    m_mode_prev = 2'd0;
    for (int c = 0; c < 3; c++) begin
      m_duty[c] = 0;
      m_pin[c]  = 1;
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_clock();
    int fwd = 0;
    int rev = 0;
    int changed = (mode != m_mode_prev) ? 1 : 0;
    if (mode == 2'd0 || mode == 2'd3) begin
      m_age = changed ? 1 : m_age + 1;
      if (m_age == SD) begin
        m_age = 0;
        if (mode == 2'd0) fwd = 1; else rev = 1;
      end
    end else begin
      m_age = 0;
    end
    if (mode == 2'd2 && !changed && step_req && !m_req_prev) fwd = 1;
    m_req_prev  = changed ? 0 : int'(step_req);
    m_mode_prev = mode;
    for (int c = 0; c < 3; c++) m_pin[c] = (m_duty[c] > m_cnt) ? 0 : 1;
    if (m_cnt == MAXV)
      for (int c = 0; c < 3; c++) m_duty[c] = ref_duty(c, m_pos);
    m_cnt  = (m_cnt + 1) % LEVELS;
    m_wrap = 0;
    if (fwd) begin
      m_wrap = (m_pos == NPOS - 1) ? 1 : 0;
      m_pos  = (m_pos + 1) % NPOS;
    end
    if (rev) begin
      m_wrap = (m_pos == 0) ? 1 : 0;
      m_pos  = (m_pos + NPOS - 1) % NPOS;
    end
  endtask

  function automatic int dut_pos();
    return int'(hue_seg) * LEVELS + int'(hue_frac);
  endfunction

  task automatic check_all();
    check_eq("hue_seg", hue_seg, m_pos / LEVELS);
    check_eq("hue_frac", hue_frac, m_pos % LEVELS);
    check_eq("wrap", wrap, m_wrap);
    check_eq("pin_r", rgb_r, m_pin[0]);
    check_eq("pin_g", rgb_g, m_pin[1]);
    check_eq("pin_b", rgb_b, m_pin[2]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted between edges, held over one edge, released.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_async_r", rgb_r, 1);
    check_eq("rst_async_g", rgb_g, 1);
    check_eq("rst_async_b", rgb_b, 1);
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic step_pulse();
    step_req = 1'b1;
    cycle();
    step_req = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic count_low(output int lr, output int lg, output int lb);
    lr = 0; lg = 0; lb = 0;
    repeat (LEVELS) begin
      cycle();
      lr += (rgb_r == 1'b0) ? 1 : 0;
      lg += (rgb_g == 1'b0) ? 1 : 0;
      lb += (rgb_b == 1'b0) ? 1 : 0;
    end
  endtask

  initial begin
    int lr, lg, lb, start, g1, g2, guard;

    // reset state
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // 2. run from reset: one level per 4 clk, full circle in 192 clk
    mode = 2'd0;
    for (int i = 1; i <= 193; i++) begin
      cycle();
      if (i == 4)   check_eq("t2_first_step", hue_frac, 1);
      if (i == 32)  check_eq("t2_seg1", hue_seg, 1);
      if (i == 192) begin
        check_eq("t2_circle_seg", hue_seg, 0);
        check_eq("t2_circle_frac", hue_frac, 0);
        check_eq("t2_wrap_hi", wrap, 1);
      end
      if (i == 193) check_eq("t2_wrap_lo", wrap, 0);
    end

    // 1. reset mid-run at seg3, then hold
    guard = 0;
    while (m_pos / LEVELS != 3 && guard < 200) begin
      cycle();
      guard++;
    end
    check_eq("t1_seek_seg", hue_seg, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t1_pin_r", rgb_r, 1);
    check_eq("t1_pin_g", rgb_g, 1);
    check_eq("t1_pin_b", rgb_b, 1);
    check_eq("t1_seg", hue_seg, 0);
    check_eq("t1_frac", hue_frac, 0);
    check_eq("t1_wrap", wrap, 0);
    model_reset();
    mode = 2'd1;
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cycle();
      if (i <= 8) check_eq("t1_idle_r", rgb_r, 1);
      if (i == 9) check_eq("t1_r_on", rgb_r, 0);
    end

    // 3. hold at seg0 f=3, then seg1 f=3: count low cycles per frame
    mode = 2'd2;
    cycle();
    repeat (3) step_pulse();
    mode = 2'd1;
    repeat (18) cycle();
    check_eq("t3a_pos", dut_pos(), 3);
    count_low(lr, lg, lb);
    check_eq("t3a_r_low", lr, 7);
    check_eq("t3a_g_low", lg, 3);
    check_eq("t3a_b_low", lb, 0);
    mode = 2'd2;
    cycle();
    repeat (8) step_pulse();
    mode = 2'd1;
    repeat (18) cycle();
    check_eq("t3b_pos", dut_pos(), 11);
    count_low(lr, lg, lb);
    check_eq("t3b_r_low", lr, 4);
    check_eq("t3b_g_low", lg, 7);
    check_eq("t3b_b_low", lb, 0);

    // 4. reverse from seg0 f=0
    mode = 2'd3;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (i == 4) begin
        check_eq("t4_seg", hue_seg, 5);
        check_eq("t4_frac", hue_frac, 7);
        check_eq("t4_wrap", wrap, 1);
      end
      if (i == 8) check_eq("t4_next_frac", hue_frac, 6);
    end

    // 5. single-step: long high, short pulses, pulses ignored in hold
    mode = 2'd2;
    cycle();
    cycle();
    start = m_pos;
    step_req = 1'b1;
    repeat (10) cycle();
    step_req = 1'b0;
    repeat (3) cycle();
    check_eq("t5_long_high", dut_pos(), (start + 1) % NPOS);
    start = m_pos;
    repeat (3) step_pulse();
    check_eq("t5_three_pulses", dut_pos(), (start + 3) % NPOS);
    mode = 2'd1;
    cycle();
    start = m_pos;
    repeat (3) step_pulse();
    check_eq("t5_hold_ignored", dut_pos(), start);

    // 6. tick coinciding with frame end latches the pre-step hue
    mode = 2'd0;
    do_reset();
    g1 = 0;
    g2 = 0;
    for (int i = 1; i <= 24; i++) begin
      cycle();
      if (i >= 9 && i <= 16) g1 += (rgb_g == 1'b0) ? 1 : 0;
      if (i >= 17)           g2 += (rgb_g == 1'b0) ? 1 : 0;
    end
    check_eq("t6_frame1_g", g1, 1);
    check_eq("t6_frame2_g", g2, 3);
    // run -> hold -> run: next tick a full 4 clk after returning to run
    mode = 2'd1;
    repeat (3) cycle();
    mode = 2'd0;
    start = m_pos;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      if (i == 3) check_eq("t6_no_early_tick", dut_pos(), start);
      if (i == 4) check_eq("t6_tick_after_4", dut_pos(), (start + 1) % NPOS);
    end

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      step_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
